// File: rtl/apb_timer_slave.sv
// APB zero-wait-state responder with a 32-bit down-counting timer, prescaler,
// periodic/one-shot modes and a level interrupt.
module apb_timer_slave #(
  parameter int PRESCALE_W = 8
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        IRQ
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                  state_q, state_d;
  logic [31:0]             prdata_q, prdata_d;
  logic                    en_q, en_d;
  logic                    periodic_q, periodic_d;
  logic                    irq_en_q, irq_en_d;
  logic [PRESCALE_W-1:0]   prescale_q, prescale_d;
  logic [PRESCALE_W-1:0]   presc_q, presc_d;
  logic [31:0]             load_q, load_d;
  logic [31:0]             value_q, value_d;
  logic                    expired_q, expired_d;
  logic [31:0]             scratch_q, scratch_d;

  logic [2:0]  addr;
  logic        setup_phase, access_phase, wr_en, rd_setup;
  logic        ctrl_wr, load_wr, status_wr, scratch_wr;
  logic        tick, tick_eff;
  logic [31:0] rdata;
  logic        unused_paddr;

  assign addr         = PADDR[4:2];
  assign unused_paddr = ^{PADDR[31:5], PADDR[1:0]};

  // The state names the bus phase that just completed at the last edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (PSEL && !PENABLE) state_d = SETUP;
      SETUP:   if (!PSEL) state_d = IDLE;
               else if (PENABLE) state_d = ACCESS;
      ACCESS:  state_d = (PSEL && !PENABLE) ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign setup_phase  = PSEL && !PENABLE && (state_q != SETUP);
  assign access_phase = PSEL && PENABLE && (state_q == SETUP);
  assign wr_en        = access_phase && PWRITE;
  assign rd_setup     = setup_phase && !PWRITE;

  assign ctrl_wr    = wr_en && (addr == 3'd0);
  assign load_wr    = wr_en && (addr == 3'd1);
  assign status_wr  = wr_en && (addr == 3'd3);
  assign scratch_wr = wr_en && (addr == 3'd4);

  always_comb begin
    rdata = '0;
    case (addr)
      3'd0: begin
        rdata[0]                = en_q;
        rdata[1]                = periodic_q;
        rdata[2]                = irq_en_q;
        rdata[8 +: PRESCALE_W]  = prescale_q;
      end
      3'd1:    rdata = load_q;
      3'd2:    rdata = value_q;
      3'd3:    rdata[0] = expired_q;
      3'd4:    rdata = scratch_q;
      default: rdata = '0;
    endcase
  end

  assign prdata_d = rd_setup ? rdata : '0;

  assign tick     = en_q && (presc_q == prescale_q);
  // A LOAD write replaces the counter outright, so a coincident tick is dropped.
  assign tick_eff = tick && !load_wr;

  always_comb begin
    en_d       = en_q;
    periodic_d = periodic_q;
    irq_en_d   = irq_en_q;
    prescale_d = prescale_q;
    presc_d    = presc_q;
    load_d     = load_q;
    value_d    = value_q;
    expired_d  = expired_q;
    scratch_d  = scratch_q;

    if (en_q) presc_d = tick ? '0 : presc_q + 1'b1;

    if (status_wr && PWDATA[0]) expired_d = 1'b0;

    if (tick_eff) begin
      if (value_q != 32'd0) begin
        value_d = value_q - 32'd1;
      end else begin
        expired_d = 1'b1;
        if (periodic_q) value_d = load_q;
        else            en_d    = 1'b0;
      end
    end

    // Register writes come last so they override timer side effects.
    if (ctrl_wr) begin
      en_d       = PWDATA[0];
      periodic_d = PWDATA[1];
      irq_en_d   = PWDATA[2];
      prescale_d = PWDATA[8 +: PRESCALE_W];
      if (PWDATA[0] && !en_q) presc_d = '0;
    end
    if (load_wr) begin
      load_d  = PWDATA;
      value_d = PWDATA;
      presc_d = '0;
    end
    if (scratch_wr) scratch_d = PWDATA;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q    <= IDLE;
      prdata_q   <= '0;
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      irq_en_q   <= 1'b0;
      prescale_q <= '0;
      presc_q    <= '0;
      load_q     <= '0;
      value_q    <= '0;
      expired_q  <= 1'b0;
      scratch_q  <= '0;
    end else begin
      state_q    <= state_d;
      prdata_q   <= prdata_d;
      en_q       <= en_d;
      periodic_q <= periodic_d;
      irq_en_q   <= irq_en_d;
      prescale_q <= prescale_d;
      presc_q    <= presc_d;
      load_q     <= load_d;
      value_q    <= value_d;
      expired_q  <= expired_d;
      scratch_q  <= scratch_d;
    end
  end

  assign PRDATA = prdata_q;
  assign IRQ    = expired_q & irq_en_q;

endmodule

// File: tb/tb_apb_timer_slave.sv
// Directed bench for apb_timer_slave: stimulus queues expected values, a
// negedge monitor pops and compares whenever read data or a probe is presented.
module tb_apb_timer_slave;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        IRQ;

  int checks = 0;
  int errors = 0;

  int          kind_q[$];
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        probe_r = 1'b0;

  localparam int K_PRDATA = 0;
  localparam int K_IRQ    = 1;

  apb_timer_slave #(.PRESCALE_W(8)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .IRQ     (IRQ)
  );

  always #5 HCLK = ~HCLK;

  // Monitor: read ACCESS cycles and explicit probes each consume one entry.
  always @(negedge HCLK) begin
    int          k;
    logic [31:0] e;
    logic [31:0] act;
    string       n;
    if ((PSEL && PENABLE && !PWRITE) || probe_r) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output actual PRDATA=%h IRQ=%b required no output", PRDATA, IRQ);
      end else begin
        k = kind_q.pop_front();
        e = exp_q.pop_front();
        n = name_q.pop_front();
        act = (k == K_IRQ) ? {31'b0, IRQ} : PRDATA;
        if (act !== e) begin
          errors++;
          $display("FAIL %s actual=%h required=%h", n, act, e);
        end
      end
    end
  end

  task automatic push(input int kind, input logic [31:0] e, input string n);
    kind_q.push_back(kind);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, input logic [31:0] e, input string n);
    push(K_PRDATA, e, n);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Checks a signal during the current cycle, then advances one cycle.
  task automatic probe(input int kind, input logic [31:0] e, input string n);
    push(kind, e, n);
    probe_r = 1'b1;
    @(negedge HCLK); #1;
    probe_r = 1'b0;
    @(posedge HCLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    HRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    repeat (3) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;

    // Reset state
    probe(K_IRQ, 32'd0, "rst_irq");
    probe(K_PRDATA, 32'd0, "rst_prdata");
    for (int i = 0; i < 8; i++) apb_read(32'(i * 4), 32'd0, $sformatf("rst_rd%0d", i));

    // Scratch, unmapped offset, read-only VALUE, ignored high address bits
    apb_write(32'h10, 32'hDEADBEEF);
    apb_read(32'h10, 32'hDEADBEEF, "scratch_b2b");
    apb_write(32'h18, 32'h12345678);
    apb_read(32'h18, 32'd0, "off6_rd");
    apb_read(32'h10, 32'hDEADBEEF, "scratch_after_off6");
    apb_write(32'h08, 32'h55);
    apb_read(32'h08, 32'd0, "value_wr_ignored");
    apb_read(32'hFFFF_FF10, 32'hDEADBEEF, "scratch_hi_addr");

    // One-shot, PRESCALE=0: expiry 4 cycles after EN
    apb_write(32'h04, 32'd3);
    apb_write(32'h00, 32'h5);
    for (int k = 0; k < 4; k++) probe(K_IRQ, 32'd0, $sformatf("oneshot_irq_c%0d", k));
    probe(K_IRQ, 32'd1, "oneshot_irq_rise");
    apb_read(32'h00, 32'h4, "oneshot_ctrl_en_clr");
    apb_read(32'h08, 32'd0, "oneshot_value0");
    apb_read(32'h0C, 32'd1, "oneshot_expired");
    apb_write(32'h0C, 32'd1);
    probe(K_IRQ, 32'd0, "oneshot_irq_w1c");

    // One-shot, PRESCALE=1: VALUE sampled every two cycles
    apb_write(32'h04, 32'd3);
    apb_write(32'h00, 32'h101);
    apb_read(32'h08, 32'd3, "cnt_v3");
    apb_read(32'h08, 32'd2, "cnt_v2");
    apb_read(32'h08, 32'd1, "cnt_v1");
    apb_read(32'h08, 32'd0, "cnt_v0");
    apb_read(32'h08, 32'd0, "cnt_v0_hold");
    apb_read(32'h0C, 32'd1, "cnt_expired");
    apb_write(32'h0C, 32'd1);

    // Periodic, PRESCALE=2, LOAD=2: expiry every 9 cycles
    apb_write(32'h04, 32'd2);
    apb_write(32'h00, 32'h207);
    for (int k = 0; k < 9; k++) probe(K_IRQ, 32'd0, $sformatf("per_irq_c%0d", k));
    probe(K_IRQ, 32'd1, "per_irq_rise");
    apb_write(32'h0C, 32'd1);
    probe(K_IRQ, 32'd0, "per_irq_w1c");
    idle(3);
    apb_write(32'h0C, 32'd1);
    probe(K_IRQ, 32'd1, "per_set_beats_clr");
    apb_read(32'h0C, 32'd1, "per_status_set");
    apb_write(32'h00, 32'h0);
    apb_write(32'h0C, 32'd1);
    apb_read(32'h0C, 32'd0, "per_status_clr");
    apb_read(32'h08, 32'd1, "per_value_frozen");
    apb_read(32'h00, 32'd0, "per_ctrl_off");

    // PENABLE without SETUP is ignored
    idle(1);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h10; PWDATA = 32'h11111111;
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    idle(1);
    push(K_PRDATA, 32'd0, "noSetup_rd_prdata");
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 32'h10;
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    apb_read(32'h10, 32'hDEADBEEF, "noSetup_scratch_kept");

    // Reset during ACCESS of a LOAD write
    apb_write(32'h04, 32'd0);
    apb_write(32'h00, 32'h5);
    idle(1);
    probe(K_IRQ, 32'd1, "pre_rst_irq");
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h04; PWDATA = 32'h10;
    @(posedge HCLK); #1;
    PENABLE = 1'b1; HRESETn = 1'b0;
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; HRESETn = 1'b1;
    probe(K_IRQ, 32'd0, "midrst_irq");
    probe(K_PRDATA, 32'd0, "midrst_prdata");
    apb_read(32'h04, 32'd0, "midrst_load");
    apb_read(32'h10, 32'd0, "midrst_scratch");
    apb_read(32'h00, 32'd0, "midrst_ctrl");

    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain actual=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
